// File: rtl/bsg_link_ddr_downstream_assembler.sv
// Receive-side DDR assembler: pairs 2-channel beats into core words, buffers them
// in a small FIFO and returns decimated credit tokens as words are consumed.
module bsg_link_ddr_downstream_assembler #(
    parameter int CHANNEL_WIDTH    = 16,
    parameter int FIFO_DEPTH       = 8,
    parameter int TOKEN_DECIMATION = 8,
    parameter int BEATS_PER_WORD   = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [1:0]                                io_valid_i,
    input  logic [2*CHANNEL_WIDTH-1:0]                io_data_i,
    output logic [2*CHANNEL_WIDTH*BEATS_PER_WORD-1:0] core_data_o,
    output logic                                      core_valid_o,
    input  logic                                      core_yumi_i,
    output logic [1:0]                                token_o,
    output logic                                      overflow_o,
    output logic                                      err_misalign_o
);
    localparam int BEAT_W = 2 * CHANNEL_WIDTH;
    localparam int WORD_W = BEAT_W * BEATS_PER_WORD;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int TW     = $clog2(TOKEN_DECIMATION);

    logic              r_beat_idx;
    logic [BEAT_W-1:0] r_stage;
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [TW-1:0]     r_tok_cnt;
    logic [1:0]        r_token;
    logic              r_overflow;
    logic              r_misalign;

    logic              w_beat_ok;
    logic              w_misalign;
    logic              w_empty;
    logic              w_full;
    logic              w_rd;
    logic              w_wr_req;
    logic              w_wr;
    logic [TW:0]       w_tok_sum;

    assign w_beat_ok  = (io_valid_i == 2'b11);
    assign w_misalign = io_valid_i[0] ^ io_valid_i[1];
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_rd       = core_yumi_i && !w_empty;
    assign w_wr_req   = w_beat_ok && r_beat_idx;
    // A same-cycle read frees the head slot, so a full FIFO can still accept.
    assign w_wr       = w_wr_req && (!w_full || w_rd);
    assign w_tok_sum  = {1'b0, r_tok_cnt} + (TW+1)'(BEATS_PER_WORD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat_idx <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_tok_cnt  <= '0;
            r_token    <= 2'b00;
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_beat_ok)
                r_beat_idx <= ~r_beat_idx;
            if (w_misalign)
                r_misalign <= 1'b1;
            if (w_wr_req && !w_wr)
                r_overflow <= 1'b1;
            if (w_wr)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) begin
                r_rptr    <= r_rptr + (AW+1)'(1);
                r_tok_cnt <= w_tok_sum[TW-1:0];
                if (w_tok_sum[TW])
                    r_token <= ~r_token;
            end
        end
    end

    // Datapath storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_beat_ok && !r_beat_idx)
            r_stage <= io_data_i;
        if (w_wr)
            r_mem[r_wptr[AW-1:0]] <= {io_data_i, r_stage};
    end

    assign core_valid_o   = !w_empty;
    assign core_data_o    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign token_o        = r_token;
    assign overflow_o     = r_overflow;
    assign err_misalign_o = r_misalign;
endmodule

// File: tb/tb_bsg_link_ddr_downstream_assembler.sv
// Directed bench for bsg_link_ddr_downstream_assembler: vector table plus
// streaming, overflow and reset sequences.
module tb_bsg_link_ddr_downstream_assembler;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [31:0] io_data_i;
    logic [63:0] core_data_o;
    logic        core_valid_o;
    logic        core_yumi_i;
    logic [1:0]  token_o;
    logic        overflow_o;
    logic        err_misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_link_ddr_downstream_assembler dut (
        .clk           (clk),
        .rst           (rst),
        .io_valid_i    (io_valid_i),
        .io_data_i     (io_data_i),
        .core_data_o   (core_data_o),
        .core_valid_o  (core_valid_o),
        .core_yumi_i   (core_yumi_i),
        .token_o       (token_o),
        .overflow_o    (overflow_o),
        .err_misalign_o(err_misalign_o)
    );

    typedef struct {
        logic        rstn;
        logic [1:0]  v;
        logic [31:0] d;
        logic        y;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  et;
        logic        eo;
        logic        em;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rstn, logic [1:0] v, logic [31:0] d, logic y,
                                logic ev, logic [63:0] ed, logic [1:0] et, logic eo, logic em);
        vec_t r;
        r.rstn = rstn; r.v = v; r.d = d; r.y = y;
        r.ev = ev; r.ed = ed; r.et = et; r.eo = eo; r.em = em;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, let one posedge pass, settle to sample point.
    task automatic cycle(logic rstn, logic [1:0] v, logic [31:0] d, logic y);
        rst = rstn; io_valid_i = v; io_data_i = d; core_yumi_i = y;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 2'b11, 32'hFFFF_FFFF, 1'b1);
        cycle(1'b0, 2'b00, 32'h0, 1'b0);
        cycle(1'b1, 2'b00, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] lo_of(int w);
        return 32'h1000_0000 + 32'(w);
    endfunction
    function automatic logic [31:0] hi_of(int w);
        return 32'h2000_0000 + 32'(w);
    endfunction

    task automatic push_word(int w, logic y_hi);
        cycle(1'b1, 2'b11, lo_of(w), 1'b0);
        cycle(1'b1, 2'b11, hi_of(w), y_hi);
    endtask

    initial begin
        rst = 1'b0; io_valid_i = 2'b00; io_data_i = '0; core_yumi_i = 1'b0;

        // Reset held with garbage inputs
        tbl.push_back(mk(0, 2'b11, 32'hDEAD_BEEF, 1, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 32'h1234_5678, 1, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 32'hCAFE_F00D, 0, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b00, 32'h0,         0, 0, 64'h0, 2'b00, 0, 0));
        // Basic assembly
        tbl.push_back(mk(1, 2'b11, 32'h2222_1111, 0, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 32'h4444_3333, 0, 1, 64'h4444_3333_2222_1111, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b00, 32'h0,         1, 0, 64'h0, 2'b00, 0, 0));
        // Yumi while empty is ignored
        tbl.push_back(mk(1, 2'b00, 32'h0,         1, 0, 64'h0, 2'b00, 0, 0));
        // Misaligned beat dropped, flag sticky
        tbl.push_back(mk(1, 2'b01, 32'hDEAD_DEAD, 0, 0, 64'h0, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2'b11, 32'hAAAA_AAAA, 0, 0, 64'h0, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2'b10, 32'hDEAD_DEAD, 0, 0, 64'h0, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2'b11, 32'hBBBB_BBBB, 0, 1, 64'hBBBB_BBBB_AAAA_AAAA, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2'b00, 32'h0,         1, 0, 64'h0, 2'b00, 0, 1));
        // Reset mid-word discards the staged half
        tbl.push_back(mk(1, 2'b11, 32'h5555_5555, 0, 0, 64'h0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 2'b00, 32'h0,         0, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 32'hCCCC_0001, 0, 0, 64'h0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 32'hDDDD_0002, 0, 1, 64'hDDDD_0002_CCCC_0001, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b00, 32'h0,         1, 0, 64'h0, 2'b00, 0, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].rstn, tbl[i].v, tbl[i].d, tbl[i].y);
            check($sformatf("row%0d valid", i), 64'(core_valid_o), 64'(tbl[i].ev));
            check($sformatf("row%0d data", i), core_data_o, tbl[i].ed);
            check($sformatf("row%0d token", i), 64'(token_o), 64'(tbl[i].et));
            check($sformatf("row%0d overflow", i), 64'(overflow_o), 64'(tbl[i].eo));
            check($sformatf("row%0d misalign", i), 64'(err_misalign_o), 64'(tbl[i].em));
        end

        // Streaming with yumi always high: token toggles every 4 consumed words
        do_reset();
        for (int w = 0; w < 16; w++) begin
            cycle(1'b1, 2'b11, lo_of(w), 1'b1);
            check($sformatf("stream token after %0d", w), 64'(token_o),
                  64'((((w / 4) % 2) == 1) ? 2'b11 : 2'b00));
            cycle(1'b1, 2'b11, hi_of(w), 1'b1);
            check($sformatf("stream valid w%0d", w), 64'(core_valid_o), 64'(1'b1));
            check($sformatf("stream data w%0d", w), core_data_o, {hi_of(w), lo_of(w)});
        end
        cycle(1'b1, 2'b00, 32'h0, 1'b1);
        check("stream final valid", 64'(core_valid_o), 64'(1'b0));
        check("stream final token", 64'(token_o), 64'(2'b00));

        // Overflow: 9th word dropped when full and no yumi
        do_reset();
        for (int w = 0; w < 8; w++) push_word(w, 1'b0);
        check("fill overflow", 64'(overflow_o), 64'(1'b0));
        push_word(8, 1'b0);
        check("ovf set", 64'(overflow_o), 64'(1'b1));
        for (int w = 0; w < 8; w++) begin
            check($sformatf("ovf drain w%0d", w), core_data_o, {hi_of(w), lo_of(w)});
            cycle(1'b1, 2'b00, 32'h0, 1'b1);
        end
        check("ovf drained empty", 64'(core_valid_o), 64'(1'b0));
        check("ovf token", 64'(token_o), 64'(2'b00));

        // Full with same-cycle yumi: write accepted, no overflow
        do_reset();
        for (int w = 0; w < 8; w++) push_word(w, 1'b0);
        push_word(8, 1'b1);
        check("full+yumi overflow", 64'(overflow_o), 64'(1'b0));
        for (int w = 1; w < 9; w++) begin
            check($sformatf("full+yumi valid w%0d", w), 64'(core_valid_o), 64'(1'b1));
            check($sformatf("full+yumi drain w%0d", w), core_data_o, {hi_of(w), lo_of(w)});
            cycle(1'b1, 2'b00, 32'h0, 1'b1);
        end
        check("full+yumi empty", 64'(core_valid_o), 64'(1'b0));
        check("full+yumi empty data", core_data_o, 64'h0);
        check("full+yumi token", 64'(token_o), 64'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsg_link_ddr_downstream_assembler.md
Name: bsg_link_ddr_downstream_assembler

Overview:
- Receive-side stage paired with bsg_link_ddr_upstream.
- Consumes the per-cycle 2-channel, 16-bit-per-channel beats after DDR capture.
- Reassembles 64-bit core words from two 32-bit beats ({ch1[15:0], ch0[15:0]}) and buffers them in a small FIFO.
- Returns decimated credit tokens to the upstream sender as each word is consumed by the core.

Parameters:
- CHANNEL_WIDTH, 16, data bits per channel per beat (beat width = 2*CHANNEL_WIDTH).
- FIFO_DEPTH, 8, words of buffering; power of two, >= 2.
- TOKEN_DECIMATION, 8, beats consumed per token toggle; power of two, >= BEATS_PER_WORD.
- BEATS_PER_WORD, 2, beats per core word; fixed at 2.

Ports:
- clk  in  1  io-domain clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- io_valid_i  in  2  per-channel beat valid, bit0 = ch0, bit1 = ch1.
- io_data_i  in  2*CHANNEL_WIDTH  beat data, {ch1, ch0}.
- core_data_o  out  64  head-of-FIFO word, {beat1, beat0}.
- core_valid_o  out  1  FIFO non-empty.
- core_yumi_i  in  1  core consumes head word this cycle.
- token_o  out  2  per-channel token level; toggles signal credit return.
- overflow_o  out  1  sticky: word arrived with FIFO full and no same-cycle yumi.
- err_misalign_o  out  1  sticky: io_valid_i was 2'b01 or 2'b10.

Behaviour:
- Reset values: core_valid_o=0, core_data_o=0, token_o=2'b00, overflow_o=0, err_misalign_o=0. Reset also clears beat index, FIFO pointers and token counter.
- Reset mid-operation discards any partial word and all buffered words.
- Beat acceptance:
  - io_valid_i==2'b11 accepts a beat.
  - 2'b00 is idle.
  - 2'b01 or 2'b10: beat dropped, err_misalign_o set (sticky until reset), beat index unchanged.
- Assembly:
  - 1-bit beat_idx.
  - beat_idx=0: io_data_i captured into low staging register, beat_idx<=1.
  - beat_idx=1: word {io_data_i, staged} written to FIFO tail on the same edge, beat_idx<=0.
- Latency: second beat sampled at edge t, FIFO previously empty -> core_valid_o=1 and core_data_o valid after edge t (visible in cycle t+1).
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - Empty when pointers are equal; full when indices are equal and wrap bits differ.
- Write rules:
  - Write permitted when not full, or when full with core_yumi_i=1 in the same cycle (read frees the slot first).
  - Full without yumi: word dropped, overflow_o set sticky, pointers unchanged.
- Read rules:
  - core_yumi_i honoured only when core_valid_o=1; yumi while empty is ignored (no pointer or token change).
  - core_data_o is 0 while empty.
- Simultaneous read and write: both occur; occupancy unchanged; when depth==1 entry the new word appears as head after the edge.
- Token return:
  - beat counter of log2(TOKEN_DECIMATION) bits; each accepted yumi adds BEATS_PER_WORD.
  - On wrap of the counter (sum >= TOKEN_DECIMATION), both bits of token_o toggle on that edge.
  - Defaults: one toggle per 4 consumed words.
- Tokens depend only on consumption, never on dropped beats or overflowed words.
- Occupancy never exceeds FIFO_DEPTH; pointer arithmetic wraps modulo 2*FIFO_DEPTH.

Test Plan:
- Reset hold 3 cycles with garbage inputs, release -> all outputs 0, core_valid_o=0.
- Beats 32'h2222_1111 then 32'h4444_3333 on consecutive cycles, yumi tied 0 -> next cycle core_valid_o=1, core_data_o=64'h4444_3333_2222_1111.
- 16 words streamed with yumi high every cycle -> all 16 words out in order; token_o toggles 00->11->00->11->00 after words 4, 8, 12, 16.
- Fill 8 words with yumi=0, then a 9th word -> overflow_o=1 and the 9th word is absent. Repeat from reset, sending the 9th word with yumi=1 on its write cycle -> overflow_o=0, 8 words buffered, 9th word last.
- Beat with io_valid_i=2'b01, then valid beats A, B -> err_misalign_o=1, output word {B, A}.
- First beat sent, rst pulsed low for one cycle, then beats C, D -> output word {D, C}; no stale half-word.
